// File: rtl/lcd_char_writer_if.sv
// Character request handshake and HD44780 8-bit parallel bus, grouped for the writer.
interface lcd_char_writer_if;
    logic [7:0] char_data;
    logic       char_req;
    logic       char_done;
    logic       ready;
    logic [7:0] lcd_data;
    logic       lcd_rs;
    logic       lcd_rw;
    logic       lcd_e;
    logic       lcd_on;

    modport master (
        output char_data, char_req,
        input  char_done, ready, lcd_data, lcd_rs, lcd_rw, lcd_e, lcd_on
    );

    modport slave (
        input  char_data, char_req,
        output char_done, ready, lcd_data, lcd_rs, lcd_rw, lcd_e, lcd_on
    );
endinterface

// File: rtl/lcd_char_writer.sv
// Writes one requested character to an HD44780 panel: power-up init, then clear + char per request.
module lcd_char_writer #(
    parameter int unsigned POWERUP_WAIT_CYC = 1000000,
    parameter int unsigned E_PULSE_CYC      = 25,
    parameter int unsigned CMD_WAIT_CYC     = 2500,
    parameter int unsigned CLEAR_WAIT_CYC   = 100000
) (
    input logic              clk,
    input logic              rst,
    lcd_char_writer_if.slave bus
);
    localparam int unsigned CNT_W  = 24;
    localparam int unsigned DATA_W = 8;

    localparam logic [DATA_W-1:0] CMD_CLEAR  = 8'h01;
    localparam logic [CNT_W-1:0]  PWR_LAST   = CNT_W'(POWERUP_WAIT_CYC - 1);
    localparam logic [CNT_W-1:0]  SETUP_LAST = CNT_W'(1);
    localparam logic [CNT_W-1:0]  E_LAST     = CNT_W'(E_PULSE_CYC - 1);
    localparam logic [CNT_W-1:0]  CMD_LAST   = CNT_W'(CMD_WAIT_CYC - 1);
    localparam logic [CNT_W-1:0]  CLR_LAST   = CNT_W'(CLEAR_WAIT_CYC - 1);

    typedef enum logic [2:0] {PWR_WAIT, INIT, IDLE, CLR, CHAR, DONE} stateT;
    typedef enum logic [1:0] {SETUP, EHIGH, WAIT} phaseT;

    stateT             state, stateNext;
    phaseT             phase, phaseNext;
    logic [CNT_W-1:0]  cnt, cntNext, phaseLast;
    logic [1:0]        initIdx, initIdxNext;
    logic [DATA_W-1:0] charLatch, charLatchNext;
    logic [DATA_W-1:0] lcdData, lcdDataNext;
    logic              lcdRs, lcdRsNext;
    logic              lcdE, lcdENext;
    logic              charDone, charDoneNext;
    logic              readyReg, readyNext;

    function automatic logic [DATA_W-1:0] initCmd(input logic [1:0] idx);
        case (idx)
            2'd0:    initCmd = 8'h38;
            2'd1:    initCmd = 8'h0C;
            2'd2:    initCmd = 8'h01;
            default: initCmd = 8'h06;
        endcase
    endfunction

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= PWR_WAIT;
            phase     <= SETUP;
            cnt       <= '0;
            initIdx   <= '0;
            charLatch <= '0;
            lcdData   <= '0;
            lcdRs     <= 1'b0;
            lcdE      <= 1'b0;
            charDone  <= 1'b0;
            readyReg  <= 1'b0;
        end else begin
            state     <= stateNext;
            phase     <= phaseNext;
            cnt       <= cntNext;
            initIdx   <= initIdxNext;
            charLatch <= charLatchNext;
            lcdData   <= lcdDataNext;
            lcdRs     <= lcdRsNext;
            lcdE      <= lcdENext;
            charDone  <= charDoneNext;
            readyReg  <= readyNext;
        end
    end

    // Next state; outputs are derived from the next state so they line up with it
    always_comb begin
        stateNext     = state;
        phaseNext     = phase;
        cntNext       = cnt + CNT_W'(1);
        initIdxNext   = initIdx;
        charLatchNext = charLatch;
        lcdDataNext   = lcdData;
        lcdRsNext     = lcdRs;

        // The write currently on the bus decides how long its wait phase is
        case (phase)
            SETUP:   phaseLast = SETUP_LAST;
            EHIGH:   phaseLast = E_LAST;
            default: phaseLast = (!lcdRs && lcdData == CMD_CLEAR) ? CLR_LAST : CMD_LAST;
        endcase

        case (state)
            PWR_WAIT: begin
                if (cnt == PWR_LAST) begin
                    stateNext   = INIT;
                    phaseNext   = SETUP;
                    initIdxNext = 2'd0;
                    cntNext     = '0;
                end
            end
            INIT, CLR, CHAR: begin
                if (cnt == phaseLast) begin
                    cntNext = '0;
                    case (phase)
                        SETUP: phaseNext = EHIGH;
                        EHIGH: phaseNext = WAIT;
                        default: begin
                            phaseNext = SETUP;
                            case (state)
                                INIT: begin
                                    if (initIdx == 2'd3) stateNext = IDLE;
                                    else                 initIdxNext = initIdx + 2'd1;
                                end
                                CLR:     stateNext = CHAR;
                                default: stateNext = DONE;
                            endcase
                        end
                    endcase
                end
            end
            IDLE: begin
                cntNext = '0;
                if (bus.char_req) begin
                    charLatchNext = bus.char_data;
                    stateNext     = CLR;
                    phaseNext     = SETUP;
                end
            end
            default: begin
                cntNext = '0;
                if (!bus.char_req) stateNext = IDLE;
            end
        endcase

        case (stateNext)
            INIT: begin
                lcdDataNext = initCmd(initIdxNext);
                lcdRsNext   = 1'b0;
            end
            CLR: begin
                lcdDataNext = CMD_CLEAR;
                lcdRsNext   = 1'b0;
            end
            CHAR: begin
                lcdDataNext = charLatchNext;
                lcdRsNext   = 1'b1;
            end
            default: ;
        endcase

        lcdENext     = (phaseNext == EHIGH) &&
                       (stateNext == INIT || stateNext == CLR || stateNext == CHAR);
        readyNext    = (stateNext == IDLE);
        charDoneNext = (stateNext == DONE);
    end

    assign bus.lcd_data  = lcdData;
    assign bus.lcd_rs    = lcdRs;
    assign bus.lcd_e     = lcdE;
    assign bus.lcd_rw    = 1'b0;
    assign bus.lcd_on    = 1'b1;
    assign bus.char_done = charDone;
    assign bus.ready     = readyReg;
endmodule

// File: tb/tb_lcd_char_writer.sv
// Randomized bench for lcd_char_writer against an arithmetic timeline model of the bus writes.
module tb_lcd_char_writer;
    localparam int unsigned PWR = 10;
    localparam int unsigned EP  = 2;
    localparam int unsigned CW  = 4;
    localparam int unsigned CLW = 8;

    typedef struct {
        logic        rs;
        logic [7:0]  data;
        int unsigned rise;
        int unsigned width;
    } expWriteT;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    lcd_char_writer_if bus();

    lcd_char_writer #(
        .POWERUP_WAIT_CYC (PWR),
        .E_PULSE_CYC      (EP),
        .CMD_WAIT_CYC     (CW),
        .CLEAR_WAIT_CYC   (CLW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned cyc = 0;
    int unsigned tick = 0;
    expWriteT    expQ[$];
    bit          doneSeen = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cyc %0d", tag, obs, exp, cyc);
        end
    endtask

    // cyc = clock edges since reset release, as seen on the following falling edge
    always @(posedge clk) begin
        tick <= tick + 1;
        cyc  <= rst ? cyc + 1 : 0;
    end

    // Reference timeline: each write = 2 setup + E high + wait, clear command waits longer
    function automatic int unsigned waitLen(input logic rs, input logic [7:0] d);
        return (!rs && d == 8'h01) ? CLW : CW;
    endfunction

    task automatic modelWrite(input logic rs, input logic [7:0] d, inout int unsigned t);
        expWriteT w;
        w.rs = rs; w.data = d; w.rise = t + 2; w.width = EP;
        expQ.push_back(w);
        t += 2 + EP + waitLen(rs, d);
    endtask

    task automatic modelInit(output int unsigned readyT);
        int unsigned t = PWR;
        modelWrite(1'b0, 8'h38, t);
        modelWrite(1'b0, 8'h0C, t);
        modelWrite(1'b0, 8'h01, t);
        modelWrite(1'b0, 8'h06, t);
        readyT = t;
    endtask

    task automatic modelChar(input int unsigned t0, input logic [7:0] ch, output int unsigned doneT);
        int unsigned t = t0 + 1;
        modelWrite(1'b0, 8'h01, t);
        modelWrite(1'b1, ch, t);
        doneT = t;
    endtask

    // Bus monitor: every lcd_e pulse is matched against the model queue
    int unsigned riseCyc, riseTick;
    logic [7:0]  riseData;
    logic        riseRs;
    bit          ePrev = 1'b0;
    always @(negedge clk) begin
        expWriteT w;
        if (bus.lcd_e === 1'b1 && !ePrev) begin
            riseCyc = cyc; riseTick = tick; riseData = bus.lcd_data; riseRs = bus.lcd_rs;
        end else if (bus.lcd_e === 1'b1) begin
            check("bus_stable", {23'd0, bus.lcd_rs, bus.lcd_data}, {23'd0, riseRs, riseData});
        end
        if (bus.lcd_e !== 1'b1 && ePrev) begin
            check("pulse_expected", 32'(expQ.size() != 0), 32'd1);
            if (expQ.size() != 0) begin
                w = expQ.pop_front();
                check("pulse_rs", 32'(riseRs), 32'(w.rs));
                check("pulse_data", 32'(riseData), 32'(w.data));
                check("pulse_rise", riseCyc, w.rise);
                check("pulse_width", tick - riseTick, w.width);
            end
        end
        ePrev = (bus.lcd_e === 1'b1);
        if (bus.char_done === 1'b1) doneSeen = 1'b1;
    end

    task automatic resetCycles(input int unsigned n);
        repeat (n) begin
            @(negedge clk);
            check("rst_lcd_e", 32'(bus.lcd_e), 32'd0);
            check("rst_lcd_rs", 32'(bus.lcd_rs), 32'd0);
            check("rst_lcd_rw", 32'(bus.lcd_rw), 32'd0);
            check("rst_lcd_data", 32'(bus.lcd_data), 32'd0);
            check("rst_lcd_on", 32'(bus.lcd_on), 32'd1);
            check("rst_char_done", 32'(bus.char_done), 32'd0);
            check("rst_ready", 32'(bus.ready), 32'd0);
        end
    endtask

    task automatic waitReady(input int unsigned bound);
        int unsigned n = 0;
        while (bus.ready !== 1'b1 && n < bound) begin @(negedge clk); n++; end
        check("ready_wait", 32'(bus.ready), 32'd1);
    endtask

    task automatic waitDone(input int unsigned bound);
        int unsigned n = 0;
        while (bus.char_done !== 1'b1 && n < bound) begin @(negedge clk); n++; end
        check("done_wait", 32'(bus.char_done), 32'd1);
    endtask

    // One request from IDLE: pulsed or held for 'hold' extra cycles, data optionally changed after acceptance
    task automatic doTxn(input logic [7:0] ch, input bit pulse, input int unsigned hold, input bit change);
        int unsigned t, doneT;
        t = cyc;
        check("txn_ready", 32'(bus.ready), 32'd1);
        bus.char_data = ch;
        bus.char_req  = 1'b1;
        modelChar(t, ch, doneT);
        @(negedge clk);
        check("txn_ready_drop", 32'(bus.ready), 32'd0);
        if (pulse)  bus.char_req  = 1'b0;
        if (change) bus.char_data = ~ch;
        waitDone(100);
        check("txn_done_time", cyc, doneT);
        if (!pulse) begin
            repeat (hold) begin
                @(negedge clk);
                check("txn_done_hold", 32'(bus.char_done), 32'd1);
            end
            bus.char_req = 1'b0;
        end
        @(negedge clk);
        check("txn_done_fall", 32'(bus.char_done), 32'd0);
        check("txn_ready_back", 32'(bus.ready), 32'd1);
        check("txn_drained", 32'(expQ.size()), 32'd0);
    endtask

    initial begin
        int unsigned readyT, doneT, t, n;
        logic [7:0]  ch;
        rst = 1'b0;
        bus.char_req  = 1'b0;
        bus.char_data = 8'h00;

        // Power-up and init
        resetCycles(3);
        rst = 1'b1;
        modelInit(readyT);
        waitReady(200);
        check("init_ready_time", cyc, readyT);

        doTxn(8'h41, 1'b0, 3, 1'b0);
        doTxn(8'h41, 1'b0, 1, 1'b1);
        doTxn(8'($urandom_range(32, 126)), 1'b1, 0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            repeat ($urandom_range(0, 3)) begin
                @(negedge clk);
                check("idle_ready", 32'(bus.ready), 32'd1);
                check("idle_lcd_e", 32'(bus.lcd_e), 32'd0);
            end
            doTxn(8'($urandom_range(32, 126)), 1'($urandom_range(0, 1)),
                  $urandom_range(0, 4), 1'($urandom_range(0, 1)));
        end

        // Request held through reset and init: one write only
        ch = 8'($urandom_range(32, 126));
        bus.char_data = ch;
        bus.char_req  = 1'b1;
        rst = 1'b0;
        resetCycles(3);
        rst = 1'b1;
        modelInit(readyT);
        modelChar(readyT, ch, doneT);
        waitReady(200);
        check("held_ready_time", cyc, readyT);
        waitDone(100);
        check("held_done_time", cyc, doneT);
        repeat (30) begin
            @(negedge clk);
            check("held_done_level", 32'(bus.char_done), 32'd1);
            check("held_no_ready", 32'(bus.ready), 32'd0);
        end
        bus.char_req = 1'b0;
        @(negedge clk);
        check("held_done_fall", 32'(bus.char_done), 32'd0);
        check("held_ready_back", 32'(bus.ready), 32'd1);

        // Reset while the character pulse is high
        ch = 8'($urandom_range(32, 126));
        t = cyc;
        bus.char_data = ch;
        bus.char_req  = 1'b1;
        modelChar(t, ch, doneT);
        n = 0;
        while (cyc != t + 2 + 12 + 1 && n < 50) begin @(negedge clk); n++; end
        check("abort_e_high", 32'(bus.lcd_e), 32'd1);
        check("abort_rs", 32'(bus.lcd_rs), 32'd1);
        expQ[expQ.size() - 1].width = 1;
        rst = 1'b0;
        bus.char_req = 1'b0;
        doneSeen = 1'b0;
        resetCycles(3);
        rst = 1'b1;
        modelInit(readyT);
        waitReady(200);
        check("abort_ready_time", cyc, readyT);
        check("abort_no_done", 32'(doneSeen), 32'd0);
        @(negedge clk);
        check("final_drained", 32'(expQ.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
